hex_display_scan: RTL and testbench
===================================

HEX_DISPLAY_SCAN -- requirements
Module: hex_display_scan

Interface
REQ-001 Parameter REFRESH_DIV, default 1024, sets the clock cycles each digit is lit; legal range 2..65535.
REQ-002 Parameter BLANK_CYC, default 4, sets the clock cycles all segments are dark between digits; legal range 1..REFRESH_DIV-1.
REQ-003 Parameter LZB, default 1, enables leading-zero blanking of the high digit when 1.
REQ-004 Port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 Port value, input, 8 bits: accumulator byte to display, low nibble on digit 0, high nibble on digit 1.
REQ-007 Port load, input, 1 bit: when high at a rising edge, value is captured.
REQ-008 Port seg, output, 7 bits: active-high segments, bit0=a through bit6=g.
REQ-009 Port digit_sel, output, 1 bit: 0 selects the low digit, 1 selects the high digit.

Function
REQ-010 The FSM SHALL have states BLANK_TO_LO, SHOW_LO, BLANK_TO_HI and SHOW_HI, cycling in that order.
REQ-011 Each BLANK state SHALL last exactly BLANK_CYC cycles; each SHOW state SHALL last exactly REFRESH_DIV cycles; the full scan period SHALL be 2*(REFRESH_DIV+BLANK_CYC) cycles.
REQ-012 Outputs: seg=0 in both BLANK states; digit_sel=0 in BLANK_TO_LO and SHOW_LO, 1 in BLANK_TO_HI and SHOW_HI.
REQ-013 digit_sel SHALL change only on entry to a BLANK state, so the select line never changes while segments are lit.
REQ-014 In SHOW_LO, seg SHALL be the hex glyph of disp[3:0]; in SHOW_HI, the hex glyph of disp[7:4].
REQ-015 Glyphs: 0=7'h3F, 1=7'h06, 2=7'h5B, 3=7'h4F, 4=7'h66, 5=7'h6D, 6=7'h7D, 7=7'h07, 8=7'h7F, 9=7'h6F, A=7'h77, b=7'h7C, C=7'h39, d=7'h5E, E=7'h79, F=7'h71.
REQ-016 With LZB=1 and disp[7:4]=0, seg SHALL be 0 throughout SHOW_HI; the low digit is never blanked.
REQ-017 load=1 SHALL write value into a shadow register and set a pending flag.
REQ-018 The displayed register disp SHALL update only on the BLANK_TO_LO->SHOW_LO transition, and only when pending is set; pending SHALL then clear. This prevents tearing within a frame.
REQ-019 Multiple loads before a frame boundary: the last value wins.
REQ-020 A load on the same edge as the BLANK_TO_LO->SHOW_LO transition SHALL take effect on that transition, with value passed directly into disp and pending left clear.
REQ-021 seg and digit_sel SHALL depend only on registered state and disp, with no combinational path from value or load.
REQ-022 The phase counter SHALL be ceil(log2(REFRESH_DIV)) bits wide, SHALL reload to 0 on every state change, and SHALL never wrap inside a state.

Reset
REQ-023 Asserting reset_n low SHALL immediately and asynchronously force:
- state=BLANK_TO_LO, counter=0
- disp=0, shadow=0, pending=0
- seg=0, digit_sel=0
REQ-024 Reset asserted mid-frame SHALL discard any pending load.
REQ-025 After reset_n is released, the first lit cycle SHALL be BLANK_CYC cycles later, showing glyph 0 on the low digit.

Structure
REQ-026 Package hex_display_pkg SHALL hold the state enum and the 16-entry glyph constant table.
REQ-027 Sub-module hex_to_seg7 SHALL be a purely combinational 4-bit-to-7-bit glyph decoder; it SHALL be instantiated once and fed a nibble selected by the state.

Verification (bench uses REFRESH_DIV=8, BLANK_CYC=2)
REQ-028 Reset release with no load -> seg=0 for 2 cycles, then 7'h3F with digit_sel=0 for 8 cycles, then 2 blank cycles, then seg=0 with digit_sel=1 (LZB); period 20 cycles.
REQ-029 Load 8'hA5 during SHOW_HI -> the next SHOW_LO shows 7'h6D and SHOW_HI shows 7'h77; the previous value persists until then.
REQ-030 Load 8'h12 then 8'h3C within one frame -> the next frame shows 7'h39 / 7'h4F; 8'h12 is never displayed.
REQ-031 Load 8'hF0 on the exact BLANK_TO_LO->SHOW_LO edge -> the same SHOW_LO shows 7'h3F and SHOW_HI shows 7'h71.
REQ-032 Pulse reset_n low mid-SHOW_HI with a pending load of 8'h77 -> seg=0 and digit_sel=0 asynchronously; after release, glyph 0 is displayed, not 7.
REQ-033 Assertion checks on every cycle: seg==0 whenever digit_sel toggles, and the lit-run length is always exactly 8 cycles.

Source files
------------

// File: rtl/hex_display_pkg.sv
// Shared types and constants for the two-digit hex display scanner:
// scan states and the active-high seven-segment glyph table (bit0=a .. bit6=g).
package hex_display_pkg;

    typedef enum logic [1:0] {
        BLANK_TO_LO = 2'd0,
        SHOW_LO     = 2'd1,
        BLANK_TO_HI = 2'd2,
        SHOW_HI     = 2'd3
    } scanState_t;

    localparam logic [6:0] GLYPHS [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/hex_to_seg7.sv
// Purely combinational nibble-to-glyph decoder for an active-high seven-segment digit.
module hex_to_seg7
    import hex_display_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    assign o_seg = GLYPHS[i_nibble];

endmodule

// File: rtl/hex_display_scan.sv
// Two-digit multiplexed hex display scanner with blanking gaps between digits
// and a shadow register so a new value only appears at a frame boundary.
module hex_display_scan
    import hex_display_pkg::*;
#(
    parameter int REFRESH_DIV = 1024,
    parameter int BLANK_CYC   = 4,
    parameter int LZB         = 1
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] value,
    input  logic       load,
    output logic [6:0] seg,
    output logic       digit_sel
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] SHOW_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);

    scanState_t    r_state;
    logic [CW-1:0] r_cnt;
    logic [7:0]    r_disp;
    logic [7:0]    r_shadow;
    logic          r_pending;
    logic [6:0]    r_seg;
    logic          r_digitSel;

    scanState_t    w_nextState;
    logic [CW-1:0] w_last;
    logic          w_stepDone;
    logic          w_frameStart;
    logic [7:0]    w_nextDisp;
    logic [3:0]    w_nibble;
    logic [6:0]    w_glyph;
    logic [6:0]    w_nextSeg;

    // Outputs are computed for the state being entered, so seg/digit_sel come
    // straight from flops and line up exactly with the state they belong to.
    always_comb begin
        w_last       = (r_state == SHOW_LO || r_state == SHOW_HI) ? SHOW_LAST : BLANK_LAST;
        w_stepDone   = (r_cnt == w_last);
        w_nextState  = r_state;
        if (w_stepDone) begin
            case (r_state)
                BLANK_TO_LO: w_nextState = SHOW_LO;
                SHOW_LO:     w_nextState = BLANK_TO_HI;
                BLANK_TO_HI: w_nextState = SHOW_HI;
                default:     w_nextState = BLANK_TO_LO;
            endcase
        end
        w_frameStart = w_stepDone && (r_state == BLANK_TO_LO);
        w_nextDisp   = r_disp;
        if (w_frameStart) begin
            if (load) begin
                w_nextDisp = value;
            end else if (r_pending) begin
                w_nextDisp = r_shadow;
            end
        end
        w_nibble = (w_nextState == SHOW_HI) ? w_nextDisp[7:4] : w_nextDisp[3:0];
        case (w_nextState)
            SHOW_LO: w_nextSeg = w_glyph;
            SHOW_HI: w_nextSeg = ((LZB != 0) && (w_nextDisp[7:4] == 4'd0)) ? 7'd0 : w_glyph;
            default: w_nextSeg = 7'd0;
        endcase
    end

    hex_to_seg7 u_decoder (
        .i_nibble (w_nibble),
        .o_seg    (w_glyph)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= BLANK_TO_LO;
            r_cnt      <= '0;
            r_disp     <= 8'd0;
            r_shadow   <= 8'd0;
            r_pending  <= 1'b0;
            r_seg      <= 7'd0;
            r_digitSel <= 1'b0;
        end else begin
            r_state    <= w_nextState;
            r_cnt      <= w_stepDone ? '0 : r_cnt + 1'b1;
            r_disp     <= w_nextDisp;
            r_seg      <= w_nextSeg;
            r_digitSel <= (w_nextState == BLANK_TO_HI) || (w_nextState == SHOW_HI);
            if (load) begin
                r_shadow <= value;
            end
            // A load on the frame edge goes straight to disp, so nothing is left pending.
            if (w_frameStart) begin
                r_pending <= 1'b0;
            end else if (load) begin
                r_pending <= 1'b1;
            end
        end
    end

    assign seg       = r_seg;
    assign digit_sel = r_digitSel;

endmodule

// File: tb/tb_hex_display_scan.sv
// Directed bench for hex_display_scan with REFRESH_DIV=8, BLANK_CYC=2, LZB=1
// (scan period of 20 cycles), plus a per-cycle monitor on select toggles and lit runs.
module tb_hex_display_scan;

    logic       clock;
    logic       reset_n;
    logic [7:0] value;
    logic       load;
    logic [6:0] seg;
    logic       digit_sel;

    int numChecks = 0;
    int numFails  = 0;
    int pos       = 0;
    bit monEn     = 0;
    int runLen    = 0;
    logic prevSel = 1'b0;

    hex_display_scan #(
        .REFRESH_DIV (8),
        .BLANK_CYC   (2),
        .LZB         (1)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .value     (value),
        .load      (load),
        .seg       (seg),
        .digit_sel (digit_sel)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        numChecks++;
        if (observed != expected) begin
            numFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // One clock edge; afterwards we sit 1ns past it, where outputs are stable
    // and new inputs will be seen by the following edge.
    task automatic tick();
        @(posedge clock);
        #1;
        pos++;
    endtask

    task automatic advanceTo(input int k);
        while (pos < k) tick();
    endtask

    // Load is captured on edge number k.
    task automatic applyStimulus(input logic [7:0] v, input int k);
        advanceTo(k - 1);
        value = v;
        load  = 1'b1;
        tick();
        load  = 1'b0;
    endtask

    always @(negedge clock) begin
        if (monEn && reset_n) begin
            if (digit_sel != prevSel) checkOutput("segDarkOnSelToggle", int'(seg), 0);
            if (seg != 7'd0) begin
                runLen++;
            end else begin
                if (runLen != 0) checkOutput("litRunLength", runLen, 8);
                runLen = 0;
            end
        end else begin
            runLen = 0;
        end
        prevSel = digit_sel;
    end

    initial begin
        reset_n = 1'b0;
        value   = 8'd0;
        load    = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checkOutput("resetSeg", int'(seg), 0);
        checkOutput("resetSel", int'(digit_sel), 0);
        reset_n = 1'b1;
        pos     = 0;
        monEn   = 1;

        // Reset release, no load: 2 blank, 8 lit '0', 2 blank, blanked high digit
        checkOutput("postRelSeg", int'(seg), 0);
        advanceTo(1);  checkOutput("blankLo1", int'(seg), 0);
        advanceTo(2);  checkOutput("firstLit", int'(seg), 'h3F);
                       checkOutput("firstLitSel", int'(digit_sel), 0);
        advanceTo(9);  checkOutput("lastLitLo", int'(seg), 'h3F);
        advanceTo(10); checkOutput("blankHiSeg", int'(seg), 0);
                       checkOutput("blankHiSel", int'(digit_sel), 1);
        advanceTo(12); checkOutput("lzbHiSeg", int'(seg), 0);
                       checkOutput("lzbHiSel", int'(digit_sel), 1);
        advanceTo(20); checkOutput("frameWrapSel", int'(digit_sel), 0);
        advanceTo(22); checkOutput("secondFrame", int'(seg), 'h3F);

        // Load A5 during SHOW_HI: old value until next frame
        applyStimulus(8'hA5, 35);
        advanceTo(39); checkOutput("holdOldHi", int'(seg), 0);
        advanceTo(41); checkOutput("holdBlank", int'(seg), 0);
        advanceTo(42); checkOutput("a5Lo", int'(seg), 'h6D);
        advanceTo(52); checkOutput("a5Hi", int'(seg), 'h77);
                       checkOutput("a5HiSel", int'(digit_sel), 1);

        // Two loads in one frame: last wins
        applyStimulus(8'h12, 55);
        applyStimulus(8'h3C, 58);
        advanceTo(59); checkOutput("stillA5", int'(seg), 'h77);
        advanceTo(62); checkOutput("lastWinsLo", int'(seg), 'h39);
        advanceTo(72); checkOutput("lastWinsHi", int'(seg), 'h4F);

        // Load on the exact frame edge
        applyStimulus(8'hF0, 82);
        checkOutput("edgeLoadLo", int'(seg), 'h3F);
        advanceTo(92); checkOutput("edgeLoadHi", int'(seg), 'h71);
        advanceTo(102); checkOutput("edgeLoadNext", int'(seg), 'h3F);

        // Async reset mid-SHOW_HI with a pending load of 77
        applyStimulus(8'h77, 115);
        advanceTo(116); checkOutput("preResetHi", int'(seg), 'h71);
        #2;
        monEn   = 0;
        reset_n = 1'b0;
        #1;
        checkOutput("asyncRstSeg", int'(seg), 0);
        checkOutput("asyncRstSel", int'(digit_sel), 0);
        tick();
        tick();
        checkOutput("heldRstSeg", int'(seg), 0);
        reset_n = 1'b1;
        pos     = 0;
        monEn   = 1;
        advanceTo(1);  checkOutput("rst2Blank", int'(seg), 0);
        advanceTo(2);  checkOutput("rst2NoPending", int'(seg), 'h3F);
        advanceTo(12); checkOutput("rst2HiBlank", int'(seg), 0);
        advanceTo(22); checkOutput("rst2NextFrame", int'(seg), 'h3F);

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule
